fifo36_demux_sid: RTL and testbench

Frame-level demultiplexer for the 36-bit stream format: the receive-side counterpart of the fair-share/priority 2:1 stream combiners. It inspects the stream-ID line of each packet and routes the whole packet to one of two outputs, or drops it, according to setting registers. It sits between the dispatcher's DSP output and the two DSP TX chains, so each chain gets its own valid/ready pair instead of sharing one data bus with dual valids.

---
 rtl/fifo36_demux_sid_pkg.sv | 48 ++++
 rtl/fifo36_demux_sid_if.sv | 30 +++
 rtl/fifo36_demux_sid_setting_reg.sv | 33 +++
 rtl/fifo36_demux_sid.sv | 187 ++++++++++++++++++
 tb/tb_fifo36_demux_sid.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo36_demux_sid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo36_demux_sid_pkg
//  Brief    : Shared constants, state encodings and routing helper for the
//             fifo36 stream-ID demultiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo36_demux_sid_pkg;

    // fifo36 line layout
    localparam int c_sof_bit = 32;
    localparam int c_eof_bit = 33;
    localparam int c_occ_hi  = 35;
    localparam int c_occ_lo  = 34;

    // Frame FSM encodings
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_hold0 = 3'd1;
    localparam logic [2:0] c_st_emit0 = 3'd2;
    localparam logic [2:0] c_st_emit1 = 3'd3;
    localparam logic [2:0] c_st_pass  = 3'd4;
    localparam logic [2:0] c_st_drop  = 3'd5;

    // Setting-register offsets from BASE
    localparam int c_reg_sid0 = 0;
    localparam int c_reg_sid1 = 1;
    localparam int c_reg_ctrl = 2;

    typedef enum logic [1:0] {
        ROUTE_OUT0 = 2'd0,
        ROUTE_OUT1 = 2'd1,
        ROUTE_DROP = 2'd2
    } route_t;

    // out0 takes precedence when both stream IDs match
    function automatic route_t route_decide(input logic [31:0] payload,
                                            input logic [31:0] sid0,
                                            input logic [31:0] sid1,
                                            input logic [1:0]  en);
        route_t r;
        r = ROUTE_DROP;
        if (en[1] && (payload == sid1)) r = ROUTE_OUT1;
        if (en[0] && (payload == sid0)) r = ROUTE_OUT0;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo36_demux_sid_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo36_demux_sid_if
//  Brief    : Stream bundle: one fifo36 input, two fifo36 outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo36_demux_sid_if;
    logic [35:0] data_i;
    logic        src_rdy_i;
    logic        dst_rdy_o;
    logic [35:0] data0_o;
    logic [35:0] data1_o;
    logic        src0_rdy_o;
    logic        src1_rdy_o;
    logic        dst0_rdy_i;
    logic        dst1_rdy_i;

    // Upstream source and downstream sinks
    modport master (
        output data_i, src_rdy_i, dst0_rdy_i, dst1_rdy_i,
        input  dst_rdy_o, data0_o, data1_o, src0_rdy_o, src1_rdy_o
    );

    // Demultiplexer side
    modport slave (
        input  data_i, src_rdy_i, dst0_rdy_i, dst1_rdy_i,
        output dst_rdy_o, data0_o, data1_o, src0_rdy_o, src1_rdy_o
    );
endinterface
`default_nettype wire

// File: rtl/fifo36_demux_sid_setting_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo36_demux_sid_setting_reg
//  Brief    : Single addressed setting register on the settings bus.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo36_demux_sid_setting_reg #(
    parameter int ADDR  = 0,
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_strobe,
    input  wire logic [7:0]       i_addr,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_data
);
    localparam logic [7:0] c_addr = ADDR[7:0];

    logic [WIDTH-1:0] r_value;

    // Capture the bus word when our address is strobed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_strobe && (i_addr == c_addr)) begin
            r_value <= i_data;
        end
    end

    assign o_data = r_value;
endmodule
`default_nettype wire

// File: rtl/fifo36_demux_sid.sv
`default_nettype none
// ============================================================================
//  Module   : fifo36_demux_sid
//  Brief    : Routes whole fifo36 packets to out0/out1 or drops them, based
//             on the payload of the stream-ID line and two SID registers.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo36_demux_sid
    import fifo36_demux_sid_pkg::*;
#(
    parameter int BASE     = 0,
    parameter int SID_LINE = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        clear,
    input  wire logic        set_stb,
    input  wire logic [7:0]  set_addr,
    input  wire logic [31:0] set_data,
    fifo36_demux_sid_if.slave bus,
    output logic      [31:0] status
);
    logic [31:0] w_sid0;
    logic [31:0] w_sid1;
    logic [1:0]  w_en;

    logic [2:0]  r_state;
    logic [35:0] r_word0;
    logic [35:0] r_word1;
    logic        r_sel;
    logic [15:0] r_drop_cnt;
    logic [15:0] r_pass_cnt;

    logic        w_sel_dst_rdy;
    logic        w_valid;
    logic [35:0] w_data;
    logic        w_dst_rdy;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_is_sof;
    logic        w_is_eof;
    route_t      w_route;

    fifo36_demux_sid_setting_reg #(.ADDR(BASE + c_reg_sid0), .WIDTH(32)) u_sr_sid0 (
        .clk(clk), .rst(reset), .i_strobe(set_stb), .i_addr(set_addr),
        .i_data(set_data), .o_data(w_sid0)
    );

    fifo36_demux_sid_setting_reg #(.ADDR(BASE + c_reg_sid1), .WIDTH(32)) u_sr_sid1 (
        .clk(clk), .rst(reset), .i_strobe(set_stb), .i_addr(set_addr),
        .i_data(set_data), .o_data(w_sid1)
    );

    fifo36_demux_sid_setting_reg #(.ADDR(BASE + c_reg_ctrl), .WIDTH(2)) u_sr_ctrl (
        .clk(clk), .rst(reset), .i_strobe(set_stb), .i_addr(set_addr),
        .i_data(set_data[1:0]), .o_data(w_en)
    );

    // Output mux and input ready: held words in EMIT*, straight wire in PASS
    always_comb begin
        w_sel_dst_rdy = r_sel ? bus.dst1_rdy_i : bus.dst0_rdy_i;
        w_route       = route_decide(bus.data_i[31:0], w_sid0, w_sid1, w_en);
        w_is_sof      = bus.data_i[c_sof_bit];
        w_is_eof      = bus.data_i[c_eof_bit];
        w_valid       = 1'b0;
        w_data        = '0;
        w_dst_rdy     = 1'b0;
        case (r_state)
            c_st_emit0: begin
                w_valid = 1'b1;
                w_data  = r_word0;
            end
            c_st_emit1: begin
                w_valid = 1'b1;
                w_data  = r_word1;
            end
            c_st_pass: begin
                w_valid   = bus.src_rdy_i;
                w_data    = bus.data_i;
                w_dst_rdy = w_sel_dst_rdy;
            end
            default: begin
                w_dst_rdy = 1'b1;
            end
        endcase
        w_in_xfer  = bus.src_rdy_i & w_dst_rdy;
        w_out_xfer = w_valid & w_sel_dst_rdy;
    end

    assign bus.dst_rdy_o  = w_dst_rdy;
    assign bus.src0_rdy_o = w_valid & ~r_sel;
    assign bus.src1_rdy_o = w_valid &  r_sel;
    assign bus.data0_o    = w_data;
    assign bus.data1_o    = w_data;
    assign status         = {r_drop_cnt, r_pass_cnt};

    // Packet FSM; clear flushes mid-packet so the tail arrives as orphans
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_word0    <= '0;
            r_word1    <= '0;
            r_sel      <= 1'b0;
            r_drop_cnt <= '0;
            r_pass_cnt <= '0;
        end else if (clear) begin
            r_state    <= c_st_idle;
            r_drop_cnt <= '0;
            r_pass_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_in_xfer) begin
                        if (!w_is_sof) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end else begin
                            r_word0 <= bus.data_i;
                            if (SID_LINE == 0) begin
                                if (w_route == ROUTE_DROP) begin
                                    r_drop_cnt <= r_drop_cnt + 16'd1;
                                    r_state    <= w_is_eof ? c_st_idle : c_st_drop;
                                end else begin
                                    r_sel   <= (w_route == ROUTE_OUT1);
                                    r_state <= c_st_emit0;
                                end
                            end else if (w_is_eof) begin
                                // Packet ends before its stream-ID line
                                r_drop_cnt <= r_drop_cnt + 16'd1;
                            end else begin
                                r_state <= c_st_hold0;
                            end
                        end
                    end
                end
                c_st_hold0: begin
                    if (w_in_xfer) begin
                        r_word1 <= bus.data_i;
                        if (w_route == ROUTE_DROP) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                            r_state    <= w_is_eof ? c_st_idle : c_st_drop;
                        end else begin
                            r_sel   <= (w_route == ROUTE_OUT1);
                            r_state <= c_st_emit0;
                        end
                    end
                end
                c_st_emit0: begin
                    if (w_out_xfer) begin
                        if (SID_LINE != 0) begin
                            r_state <= c_st_emit1;
                        end else if (r_word0[c_eof_bit]) begin
                            r_pass_cnt <= r_pass_cnt + 16'd1;
                            r_state    <= c_st_idle;
                        end else begin
                            r_state <= c_st_pass;
                        end
                    end
                end
                c_st_emit1: begin
                    if (w_out_xfer) begin
                        if (r_word1[c_eof_bit]) begin
                            r_pass_cnt <= r_pass_cnt + 16'd1;
                            r_state    <= c_st_idle;
                        end else begin
                            r_state <= c_st_pass;
                        end
                    end
                end
                c_st_pass: begin
                    if (w_in_xfer && w_is_eof) begin
                        r_pass_cnt <= r_pass_cnt + 16'd1;
                        r_state    <= c_st_idle;
                    end
                end
                c_st_drop: begin
                    if (w_in_xfer && w_is_eof) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo36_demux_sid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo36_demux_sid
//  Brief    : Self-checking bench; DUT A uses SID_LINE=1, DUT B SID_LINE=0,
//             sharing one stimulus source selected by 'sel'.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo36_demux_sid;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [35:0] data = '0;
    logic        src_rdy = 1'b0;
    logic        sel = 1'b0;
    logic        dst0_rdy = 1'b1;
    logic        dst1_rdy = 1'b1;
    int          mode0 = 1;
    int          mode1 = 1;
    logic [31:0] status_a;
    logic [31:0] status_b;

    fifo36_demux_sid_if ifa ();
    fifo36_demux_sid_if ifb ();

    assign ifa.data_i     = data;
    assign ifb.data_i     = data;
    assign ifa.src_rdy_i  = src_rdy & ~sel;
    assign ifb.src_rdy_i  = src_rdy &  sel;
    assign ifa.dst0_rdy_i = dst0_rdy;
    assign ifb.dst0_rdy_i = dst0_rdy;
    assign ifa.dst1_rdy_i = dst1_rdy;
    assign ifb.dst1_rdy_i = dst1_rdy;

    fifo36_demux_sid #(.BASE(0), .SID_LINE(1)) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb),
        .set_addr(set_addr), .set_data(set_data), .bus(ifa), .status(status_a)
    );

    fifo36_demux_sid #(.BASE(0), .SID_LINE(0)) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb),
        .set_addr(set_addr), .set_data(set_data), .bus(ifb), .status(status_b)
    );

    always #5 clk = ~clk;

    wire        w_dst_rdy = sel ? ifb.dst_rdy_o  : ifa.dst_rdy_o;
    wire        w_src0    = sel ? ifb.src0_rdy_o : ifa.src0_rdy_o;
    wire        w_src1    = sel ? ifb.src1_rdy_o : ifa.src1_rdy_o;
    wire [35:0] w_data0   = sel ? ifb.data0_o    : ifa.data0_o;
    wire [35:0] w_data1   = sel ? ifb.data1_o    : ifa.data1_o;
    wire [31:0] w_status  = sel ? status_b       : status_a;

    // Reference model state
    logic [31:0] m_sid0 = '0;
    logic [31:0] m_sid1 = '0;
    logic [1:0]  m_en = '0;
    logic [15:0] m_drop = '0;
    logic [15:0] m_pass = '0;
    logic [35:0] exp0[$];
    logic [35:0] exp1[$];
    logic [35:0] obs0[$];
    logic [35:0] obs1[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          stalls = 0;

    task automatic check(input string tag, input logic [35:0] obsv, input logic [35:0] expv);
        n_tests++;
        assert (obsv === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obsv, expv);
        end
    endtask

    // Downstream readies: 0 = low, 1 = high, 2 = random
    initial forever begin
        @(posedge clk);
        #1;
        dst0_rdy = (mode0 == 2) ? 1'($urandom_range(0, 1)) : (mode0 == 1);
        dst1_rdy = (mode1 == 2) ? 1'($urandom_range(0, 1)) : (mode1 == 1);
    end

    // Output collector with hold-while-stalled and exclusivity checks
    logic        stall0 = 1'b0;
    logic        stall1 = 1'b0;
    logic [35:0] held0 = '0;
    logic [35:0] held1 = '0;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (stall0) begin
                check("out0_stall_valid", 36'(w_src0), 36'd1);
                check("out0_stall_data", w_data0, held0);
            end
            if (stall1) begin
                check("out1_stall_valid", 36'(w_src1), 36'd1);
                check("out1_stall_data", w_data1, held1);
            end
            if (w_src0 || w_src1) check("one_valid", 36'(w_src0 & w_src1), 36'd0);
            if (w_src0 && dst0_rdy) obs0.push_back(w_data0);
            if (w_src1 && dst1_rdy) obs1.push_back(w_data1);
            stall0 = w_src0 && !dst0_rdy;
            stall1 = w_src1 && !dst1_rdy;
            held0  = w_data0;
            held1  = w_data1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    task automatic send_line(input logic [35:0] d, input bit gaps);
        int waited;
        bit done;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            src_rdy = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        data    = d;
        src_rdy = 1'b1;
        waited  = 0;
        done    = 1'b0;
        while (!done && waited < 1000) begin
            @(negedge clk);
            if (w_dst_rdy) done = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
            waited++;
        end
        src_rdy = 1'b0;
        check("input_handshake", 36'(done), 36'd1);
    endtask

    task automatic write_reg(input int k, input logic [31:0] v);
        set_addr = 8'(k);
        set_data = v;
        set_stb  = 1'b1;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
        if (k == 0) m_sid0 = v;
        if (k == 1) m_sid1 = v;
        if (k == 2) m_en = v[1:0];
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        m_drop = '0;
        m_pass = '0;
    endtask

    // Build a packet of n lines whose SID line carries 'sid', predict its fate, send it
    task automatic run_packet(input int n, input logic [31:0] sid, input bit gaps);
        logic [35:0] lines[$];
        int sl;
        int dest;
        sl = sel ? 0 : 1;
        for (int i = 0; i < n; i++) begin
            logic [35:0] w;
            w[31:0]  = $urandom;
            w[35:34] = 2'($urandom_range(0, 3));
            w[32]    = (i == 0);
            w[33]    = (i == n - 1);
            if (i == sl) w[31:0] = sid;
            lines.push_back(w);
        end
        if (n <= sl) dest = 2;
        else if (m_en[0] && sid == m_sid0) dest = 0;
        else if (m_en[1] && sid == m_sid1) dest = 1;
        else dest = 2;
        if (dest == 0) begin
            foreach (lines[i]) exp0.push_back(lines[i]);
            m_pass++;
        end else if (dest == 1) begin
            foreach (lines[i]) exp1.push_back(lines[i]);
            m_pass++;
        end else begin
            m_drop++;
        end
        foreach (lines[i]) send_line(lines[i], gaps);
    endtask

    task automatic drain_check(input string tag);
        int w;
        w = 0;
        while ((obs0.size() < exp0.size() || obs1.size() < exp1.size()) && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check($sformatf("%s_out0_count", tag), 36'(obs0.size()), 36'(exp0.size()));
        check($sformatf("%s_out1_count", tag), 36'(obs1.size()), 36'(exp1.size()));
        for (int i = 0; i < exp0.size() && i < obs0.size(); i++)
            check($sformatf("%s_out0_line%0d", tag, i), obs0[i], exp0[i]);
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++)
            check($sformatf("%s_out1_line%0d", tag, i), obs1[i], exp1[i]);
        check($sformatf("%s_status", tag), 36'(w_status), 36'({m_drop, m_pass}));
        obs0.delete();
        obs1.delete();
        exp0.delete();
        exp1.delete();
    endtask

    initial begin
        logic [35:0] l[6];
        int r;
        logic [31:0] s;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_dst_rdy_a", 36'(ifa.dst_rdy_o), 36'd1);
        check("rst_dst_rdy_b", 36'(ifb.dst_rdy_o), 36'd1);
        check("rst_src0", 36'(ifa.src0_rdy_o), 36'd0);
        check("rst_src1", 36'(ifa.src1_rdy_o), 36'd0);
        check("rst_data0", ifa.data0_o, 36'd0);
        check("rst_data1", ifa.data1_o, 36'd0);
        check("rst_status", 36'(status_a), 36'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic routing to out0, then out1 with out0 never ready
        write_reg(0, 32'h1234);
        write_reg(1, 32'h5678);
        write_reg(2, 32'h3);
        run_packet(5, 32'h1234, 1'b0);
        drain_check("route0");
        check("route0_status_abs", 36'(w_status), 36'h0_0000_0001);
        mode0 = 0;
        run_packet(6, 32'h5678, 1'b0);
        drain_check("route1_dst0_low");
        mode0 = 1;

        // Everything dropped when both outputs disabled
        write_reg(2, 32'h0);
        stalls = 0;
        for (int p = 0; p < 3; p++) run_packet(4, 32'h1234, 1'b0);
        check("drop_no_stall", 36'(stalls), 36'd0);
        drain_check("disabled");

        // Single-line packet too short for SID_LINE=1
        write_reg(2, 32'h3);
        run_packet(1, 32'h1234, 1'b0);
        drain_check("short_a");

        // SID_LINE=0 instance
        sel = 1'b1;
        pulse_clear();
        run_packet(1, 32'h1234, 1'b0);
        drain_check("single_b");
        check("single_b_idle", 36'(w_dst_rdy), 36'd1);
        run_packet(4, 32'h5678, 1'b1);
        run_packet(3, 32'hDEAD_BEEF, 1'b1);
        drain_check("multi_b");
        sel = 1'b0;
        pulse_clear();

        // Long packet under random back-pressure
        mode0 = 2;
        run_packet(100, 32'h1234, 1'b1);
        drain_check("stall100");

        // Randomized packets and enables
        mode1 = 2;
        for (int p = 0; p < 12; p++) begin
            write_reg(2, 32'($urandom_range(0, 3)));
            r = $urandom_range(0, 2);
            s = (r == 0) ? 32'h1234 : (r == 1) ? 32'h5678 : $urandom;
            run_packet($urandom_range(1, 8), s, 1'b1);
            drain_check($sformatf("rand%0d", p));
        end
        mode0 = 1;
        mode1 = 1;
        write_reg(2, 32'h3);

        // Clear mid-packet: tail lines become orphans
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            l[i]     = {2'($urandom_range(0, 3)), (i == 5), (i == 0), $urandom};
        end
        l[1][31:0] = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            send_line(l[i], 1'b0);
            exp0.push_back(l[i]);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        pulse_clear();
        for (int i = 3; i < 6; i++) begin
            send_line(l[i], 1'b0);
            m_drop++;
        end
        drain_check("clear_orphans");
        check("clear_status_abs", 36'(w_status), 36'h0_0003_0000);
        run_packet(4, 32'h1234, 1'b0);
        drain_check("after_clear");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
